// File: rtl/vga_sync_gen.sv
// VGA timing generator. It waits for a stable, synchronised PLL lock and then
// produces sync pulses, active-video flag, pixel coordinates and line/frame strobes.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned SETTLE    = 16,
  parameter int unsigned CW        = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          LOCK,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          ACTIVE,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic          RUNNING
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_C  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  if ((64'(H_TOTAL) - 1) >= (64'd1 << CW) || (64'(V_TOTAL) - 1) >= (64'd1 << CW)) begin : g_cw_check
    $error("vga_sync_gen: CW=%0d cannot hold H_TOTAL-1=%0d or V_TOTAL-1=%0d",
           CW, H_TOTAL - 1, V_TOTAL - 1);
  end
  if (SETTLE < 1) begin : g_settle_check
    $error("vga_sync_gen: SETTLE must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          lock_meta_q, lock_s_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    x_d      = x_q;
    y_d      = y_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        settle_d = '0;
        x_d      = '0;
        y_d      = '0;
        if (lock_s_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!lock_s_q) begin
          state_d  = ST_WAIT_LOCK;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = ST_RUN;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_RUN: begin
        // Lock loss abandons the current line/frame outright; counters restart at 0.
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          x_d     = '0;
          y_d     = '0;
        end else if (x_q == H_LAST) begin
          x_d = '0;
          y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
        end else begin
          x_d = x_q + CW'(1);
        end
      end
      default: begin
        state_d  = ST_WAIT_LOCK;
        settle_d = '0;
        x_d      = '0;
        y_d      = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_WAIT_LOCK;
      settle_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      settle_q    <= settle_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  // Decodes are combinational from the counter registers so they align with X/Y.
  always_comb begin
    RUNNING     = (state_q == ST_RUN);
    X           = x_q;
    Y           = y_q;
    ACTIVE      = 1'b0;
    LINE_START  = 1'b0;
    FRAME_START = 1'b0;
    HSYNC       = ~HSYNC_POL;
    VSYNC       = ~VSYNC_POL;
    if (RUNNING) begin
      ACTIVE      = (x_q < H_VIS_C) && (y_q < V_VIS_C);
      LINE_START  = (x_q == '0);
      FRAME_START = (x_q == '0) && (y_q == '0);
      if ((x_q >= HS_START) && (x_q < HS_END)) HSYNC = HSYNC_POL;
      if ((y_q >= VS_START) && (y_q < VS_END)) VSYNC = VSYNC_POL;
    end
  end

endmodule
